// File: rtl/cnn16_pkg.sv
// Shared definitions for the CNN core memory controller.
// Holds the address/data widths and the controller FSM state encoding.
package cnn16_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_ACK,
        LD_HI,
        LD_LO
    } state_t;

endpackage

// File: rtl/cnn_ram_sp.sv
// Single-port RAM: synchronous write, registered read.
// Ports:
//   clk   - clock
//   we    - write enable (write happens on the rising edge)
//   addr  - word address shared by read and write
//   wdata - write data
//   rdata - registered read data of addr, updated every rising edge
// Contents are never cleared; there is deliberately no reset.
module cnn_ram_sp
    import cnn16_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cnn_mem_ctrl.sv
// Memory controller for the CNN core: arbitrates core word reads/writes
// against a host byte-stream program loader onto one single-port RAM.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   mem_req, mem_we          - core request / write select (sampled in IDLE)
//   address, to_memory       - core word address / write data
//   from_memory, mem_ready   - read data (held) / one-cycle completion pulse
//   load_start               - host pulse: start loading at address 0
//   load_valid, load_data    - host byte strobe / byte (high byte first)
//   load_last                - final low byte marker
//   core_hold                - high while loading
//   load_done                - one-cycle pulse when the load finishes
//   load_ovf                 - sticky: load pointer wrapped past DEPTH-1
module cnn_mem_ctrl
    import cnn16_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned DEPTH    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] from_memory,
    output logic              mem_ready,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_ovf
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [7:0]        hi, hi_nxt;
    logic [2:0]        lat_cnt, lat_cnt_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              ready_nxt, hold_nxt, done_nxt, ovf_nxt;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    cnn_ram_sp #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            rd_addr     <= '0;
            hi          <= '0;
            lat_cnt     <= '0;
            from_memory <= '0;
            mem_ready   <= 1'b0;
            core_hold   <= 1'b0;
            load_done   <= 1'b0;
            load_ovf    <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            rd_addr     <= rd_addr_nxt;
            hi          <= hi_nxt;
            lat_cnt     <= lat_cnt_nxt;
            from_memory <= dout_nxt;
            mem_ready   <= ready_nxt;
            core_hold   <= hold_nxt;
            load_done   <= done_nxt;
            load_ovf    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        rd_addr_nxt = rd_addr;
        hi_nxt      = hi;
        lat_cnt_nxt = lat_cnt;
        dout_nxt    = from_memory;
        ready_nxt   = 1'b0;
        hold_nxt    = core_hold;
        done_nxt    = 1'b0;
        ovf_nxt     = load_ovf;
        ram_we      = 1'b0;
        ram_addr    = address;
        ram_wdata   = to_memory;

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LD_HI;
                    ptr_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    hold_nxt  = 1'b1;
                end else if (mem_req) begin
                    if (mem_we) begin
                        ram_we    = 1'b1;
                        state_nxt = WR_ACK;
                    end else begin
                        // RAM read is launched on this same edge from the
                        // live address, so it counts as the first latency cycle.
                        rd_addr_nxt = address;
                        lat_cnt_nxt = 3'(READ_LAT - 1);
                        state_nxt   = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // Keep the RAM pointed at the latched address so its
                // registered output stays stable while the core changes bus.
                ram_addr = rd_addr;
                if (lat_cnt == 3'd0) begin
                    dout_nxt  = ram_rdata;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end

            WR_ACK: begin
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end

            LD_HI: begin
                if (load_valid) begin
                    hi_nxt    = load_data;
                    state_nxt = LD_LO;
                end
            end

            LD_LO: begin
                ram_addr  = ptr;
                ram_wdata = {hi, load_data};
                if (load_valid) begin
                    ram_we = 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        ptr_nxt = '0;
                        ovf_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr + 12'd1;
                    end
                    if (load_last) begin
                        state_nxt = IDLE;
                        hold_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LD_HI;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                hold_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cnn_mem_ctrl.sv
// Self-checking bench for cnn_mem_ctrl: directed steps, scoreboard queue of
// expected core completions checked by a negedge monitor.
module tb_cnn_mem_ctrl;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] to_memory = '0;
    logic [15:0] from_memory;
    logic        mem_ready;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        core_hold;
    logic        load_done;
    logic        load_ovf;

    cnn_mem_ctrl #(
        .READ_LAT(RL),
        .DEPTH   (4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .address    (address),
        .to_memory  (to_memory),
        .from_memory(from_memory),
        .mem_ready  (mem_ready),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_ovf   (load_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ready_cnt = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every mem_ready must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_done) done_cnt++;
            if (mem_ready) begin
                exp_t e;
                ready_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_rd) check("read_data", 32'(from_memory), 32'(e.data));
                end
            end
        end
    end

    function automatic logic [15:0] wd(input int i);
        return 16'((i * 40503 + 12345) & 32'hFFFF);
    endfunction

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; address = a; to_memory = d;
        @(posedge clk); #1;
        mem_req = 1'b0; mem_we = 1'b0;
        e.is_rd = 1'b0; e.data = '0; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; address = a;
        @(posedge clk); #1;
        mem_req = 1'b0;
        e.is_rd = 1'b1; e.data = d; e.cyc = cyc + RL;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic start_load(input logic with_req);
        @(negedge clk);
        load_start = 1'b1;
        if (with_req) begin
            mem_req = 1'b1; mem_we = 1'b1; address = 12'h005; to_memory = 16'hDEAD;
        end
        @(posedge clk); #1;
        load_start = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        check("hold_at_start", 32'(core_hold), 32'd1);
        check("ovf_cleared_at_start", 32'(load_ovf), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic chk_hold);
        @(negedge clk);
        if (chk_hold) check("hold_during_load", 32'(core_hold), 32'd1);
        load_valid = 1'b1; load_data = b; load_last = last;
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic end_load_checks();
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("hold_after_load", 32'(core_hold), 32'd0);
        @(posedge clk); #1;
        check("load_done_one_cycle", 32'(load_done), 32'd0);
    endtask

    initial begin
        int rc, dc;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_from_memory", 32'(from_memory), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_ovf", 32'(load_ovf), 32'd0);
        rst = 1'b0;

        // Basic write/read and a few patterns
        do_write(12'h010, 16'h1234); drain();
        do_read (12'h010, 16'h1234); drain();
        do_write(12'hFFF, 16'hFFFF); drain();
        do_write(12'h800, 16'h0000); drain();
        do_read (12'hFFF, 16'hFFFF); drain();
        do_read (12'h800, 16'h0000); drain();

        // Bus activity during RD_WAIT is ignored
        do_write(12'h020, 16'hC0DE); drain();
        do_write(12'h021, 16'h5A5A); drain();
        rc = ready_cnt;
        do_read(12'h020, 16'hC0DE);
        mem_req = 1'b1; mem_we = 1'b1; address = 12'h021; to_memory = 16'hBAD0;
        @(posedge clk); #1;
        mem_we = 1'b0; address = 12'h022;
        @(posedge clk); #1;
        mem_req = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("rdwait_one_ready", 32'(ready_cnt - rc), 32'd1);
        check("from_memory_held", 32'(from_memory), 32'hC0DE);
        do_read(12'h021, 16'h5A5A); drain();

        // Simple load
        dc = done_cnt;
        start_load(1'b0);
        send_byte(8'hAB, 1'b0, 1'b1);
        send_byte(8'hCD, 1'b0, 1'b1);
        send_byte(8'h12, 1'b0, 1'b1);
        send_byte(8'h34, 1'b1, 1'b1);
        end_load_checks();
        check("load1_done_count", 32'(done_cnt - dc), 32'd1);
        check("load1_ovf", 32'(load_ovf), 32'd0);
        do_read(12'h000, 16'hABCD); drain();
        do_read(12'h001, 16'h1234); drain();

        // load_start wins over simultaneous mem_req; load_last in LD_HI and
        // load_start during a load are ignored
        do_write(12'h005, 16'h0505); drain();
        rc = ready_cnt;
        start_load(1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'h66, 1'b0, 1'b1);
        @(negedge clk); load_start = 1'b1;
        @(posedge clk); #1; load_start = 1'b0;
        send_byte(8'h77, 1'b0, 1'b1);
        send_byte(8'h88, 1'b1, 1'b1);
        end_load_checks();
        repeat (2) @(negedge clk);
        check("dropped_req_no_ready", 32'(ready_cnt - rc), 32'd0);
        do_read(12'h005, 16'h0505); drain();
        do_read(12'h000, 16'h5566); drain();
        do_read(12'h001, 16'h7788); drain();

        // 4097-word load wraps the pointer
        dc = done_cnt;
        start_load(1'b0);
        for (int i = 0; i <= 4096; i++) begin
            logic [15:0] w;
            w = wd(i);
            if (i == 4095) check("ovf_before_wrap", 32'(load_ovf), 32'd0);
            send_byte(w[15:8], 1'b0, 1'b0);
            send_byte(w[7:0], (i == 4096), 1'b0);
        end
        end_load_checks();
        check("wrap_done_count", 32'(done_cnt - dc), 32'd1);
        check("wrap_ovf", 32'(load_ovf), 32'd1);
        do_read(12'h000, wd(4096)); drain();
        do_read(12'h001, wd(1));    drain();
        do_read(12'hFFF, wd(4095)); drain();

        // Reset during LD_LO
        dc = done_cnt;
        start_load(1'b0);
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_hold", 32'(core_hold), 32'd0);
        check("rst_mid_done", 32'(load_done), 32'd0);
        check("rst_mid_ovf", 32'(load_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - dc), 32'd0);
        check("rst_mid_hold_after", 32'(core_hold), 32'd0);
        do_read(12'h000, 16'h1122); drain();
        do_read(12'h001, wd(1));    drain();
        do_read(12'h010, wd(16));   drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed timeout required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnn_mem_ctrl.md
CNN_MEM_CTRL -- requirements
Module: cnn_mem_ctrl

Interface
REQ-001 Parameter READ_LAT, default 2, cycles from read acceptance to mem_ready (legal 1..7).
REQ-002 Parameter DEPTH, default 4096, word count of the internal 16-bit RAM (12-bit address).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, on the ports listed below.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_req  input  1  core access request, sampled only in IDLE.
REQ-007 mem_we  input  1  1 = write, 0 = read; qualified by mem_req.
REQ-008 address  input  12  core word address.
REQ-009 to_memory  input  16  core write data.
REQ-010 from_memory  output  16  read data to core; held until next read completes.
REQ-011 mem_ready  output  1  one-cycle pulse: core access complete.
REQ-012 load_start  input  1  host pulse: begin program load at address 0.
REQ-013 load_valid  input  1  host byte strobe.
REQ-014 load_data  input  8  host byte; high byte first, then low byte.
REQ-015 load_last  input  1  marks the final low byte; qualified by load_valid.
REQ-016 core_hold  output  1  high while loading; core must stall.
REQ-017 load_done  output  1  one-cycle pulse at end of load.
REQ-018 load_ovf  output  1  sticky: load pointer wrapped past DEPTH-1.

Function
REQ-019 FSM states: IDLE, RD_WAIT, WR_ACK, LD_HI, LD_LO.
REQ-020 IDLE: load_start -> LD_HI. Otherwise mem_req & mem_we -> WR_ACK. Otherwise mem_req & !mem_we -> RD_WAIT.
REQ-021 load_start SHALL take priority over a simultaneous mem_req; the dropped request gets no mem_ready and the core must re-issue it.
REQ-022 Read accepted at edge N: address latched at N; from_memory updated and mem_ready high in cycle N+READ_LAT; FSM returns to IDLE at that edge.
REQ-023 Write accepted at edge N: RAM[address] <= to_memory at edge N; mem_ready high in cycle N+1; then IDLE.
REQ-024 mem_req, mem_we, address and to_memory SHALL be ignored outside IDLE; no queuing.
REQ-025 Entering LD_HI from load_start: load pointer <= 0, load_ovf <= 0, core_hold <= 1.
REQ-026 LD_HI: load_valid captures load_data as the high byte -> LD_LO; load_last in LD_HI is ignored.
REQ-027 LD_LO: load_valid writes {hi,load_data} to RAM[ptr] and sets ptr <= ptr+1. If load_last, go to IDLE; else go to LD_HI.
REQ-028 Pointer SHALL wrap DEPTH-1 -> 0 and set load_ovf, which holds until the next load_start or reset.
REQ-029 On leaving LD_LO via load_last: core_hold <= 0 and load_done pulses for exactly one cycle, the cycle IDLE is entered.
REQ-030 load_start outside IDLE SHALL be ignored.
REQ-031 core_hold SHALL be high in LD_HI and LD_LO only.

Reset
REQ-032 Reset values: FSM=IDLE; from_memory=0; mem_ready=0; core_hold=0; load_done=0; load_ovf=0; pointer=0; latency counter=0.
REQ-033 Reset mid-operation aborts any read, write-ack or load with no mem_ready or load_done pulse.
REQ-034 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-035 FSM state encoding, ADDR_W=12 and DATA_W=16 SHALL live in shared package cnn16_pkg.
REQ-036 RAM SHALL be a sub-module cnn_ram_sp: single port, synchronous write, registered read. READ_LAT counts its read cycle.

Verification
REQ-037 Write 0x1234 to 0x010, then read 0x010 -> mem_ready at N+1 for the write; from_memory=0x1234 with mem_ready exactly 2 cycles after read acceptance.
REQ-038 load_start, then bytes 0xAB,0xCD,0x12,0x34 (last on 0x34) -> RAM[0]=0xABCD, RAM[1]=0x1234; core_hold high throughout; one load_done pulse; load_ovf=0.
REQ-039 load_start and mem_req in the same IDLE cycle -> load runs; no mem_ready for the dropped request.
REQ-040 mem_req toggled with new addresses during RD_WAIT -> ignored; exactly one mem_ready, carrying the data of the first address.
REQ-041 Load 4097 words -> word 4096 lands at address 0; load_ovf=1 after the load; load_done pulses once.
REQ-042 Assert rst during LD_LO -> core_hold=0, FSM=IDLE, no load_done; previously loaded RAM words are still readable.
